// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, and level / press / release outputs.
// Optional auto-repeat of btn_pulse while held, enabled by defining BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 500,
    parameter int unsigned REPEAT_PERIOD   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_pulse,
    output logic       btn_release,
    output logic [1:0] state_dbg
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle        = 2'b00,
        StPressWait   = 2'b01,
        StPressed     = 2'b10,
        StReleaseWait = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              pulse_q, pulse_d;
    logic              release_q, release_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax) + 1;
    localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD - 1);

    logic [RptW-1:0] rpt_q, rpt_d;
    logic            rpt_rep_q, rpt_rep_d;
    logic [RptW-1:0] rpt_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q     <= '0;
            rpt_rep_q <= 1'b0;
        end else begin
            rpt_q     <= rpt_d;
            rpt_rep_q <= rpt_rep_d;
        end
    end

    assign rpt_target = rpt_rep_q ? RptPeriodLast : RptDelayLast;
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sync) begin
                    state_d = StPressWait;
                    cnt_d   = CntW'(1);
                end
            end
            StPressWait: begin
                if (!sync) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPressed: begin
                if (!sync) begin
                    state_d = StReleaseWait;
                    cnt_d   = CntW'(1);
                end
            end
            StReleaseWait: begin
                // A bounce back to 1 keeps the press alive without a second pulse.
                if (sync) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        rpt_d     = rpt_q;
        rpt_rep_d = rpt_rep_q;
        // Count only while staying in PRESSED; any other cycle restarts the initial delay.
        if (state_q == StPressed && sync) begin
            if (rpt_q == rpt_target) begin
                pulse_d   = 1'b1;
                rpt_d     = '0;
                rpt_rep_d = 1'b1;
            end else begin
                rpt_d = rpt_q + RptW'(1);
            end
        end else begin
            rpt_d     = '0;
            rpt_rep_d = 1'b0;
        end
`endif
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected pulse/release events with their
// cycle, a negedge monitor pops and compares them; auto-repeat checks need BTN_CONDITIONER_AUTOREPEAT_EN.
module tb_btn_conditioner;

    localparam int unsigned Sync = 2;
    localparam int unsigned Deb  = 4;
    localparam int unsigned Lat  = Sync + Deb;  // edges from drive to strobe edge

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_pulse;
    logic       btn_release;
    logic [1:0] state_dbg;

    typedef struct {
        bit is_rel;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;

    btn_conditioner #(
        .SYNC_STAGES    (Sync),
        .DEBOUNCE_CYCLES(Deb),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_release(btn_release),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the scoreboard; overdue entries are misses.
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_%s: nothing seen at cycle %0d, required one",
                         e.is_rel ? "release" : "pulse", e.cyc);
            end
            if (btn_pulse && btn_release) begin
                tests++;
                fails++;
                $display("FAIL overlap: pulse and release both high at cycle %0d", cyc);
            end else if (btn_pulse || btn_release) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_%s: seen at cycle %0d, required none",
                             btn_release ? "release" : "pulse", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_rel != btn_release || e.cyc != cyc) begin
                        fails++;
                        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                                 btn_release ? "release" : "pulse", cyc,
                                 e.is_rel ? "release" : "pulse", e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input bit is_rel, input int at);
        ev_t e;
        e.is_rel = is_rel;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int lvl, input int st);
        check({name, "_level"}, int'(btn_level), lvl);
        check({name, "_state"}, int'(state_dbg), st);
    endtask

    initial begin
        int e0;
        reset   = 1'b1;
        btn_raw = 1'b0;
        tick(3);
        check_outs("reset", 0, 0);
        check("reset_pulse", int'(btn_pulse), 0);
        check("reset_release", int'(btn_release), 0);
        reset = 1'b0;
        tick(3);

        // Clean press: strobe on edge Lat after drive, then PRESSED.
        btn_raw = 1'b1;
        expect_ev(1'b0, cyc + Lat);
        tick(Lat);
        check_outs("press", 1, 2);
        tick(4);

        // Release bounce of 2 edges while pressed: no events.
        btn_raw = 1'b0;
        tick(2);
        btn_raw = 1'b1;
        tick(10);
        check_outs("bounce", 1, 2);

        // Clean release.
        btn_raw = 1'b0;
        expect_ev(1'b1, cyc + Lat);
        tick(Lat);
        check_outs("release", 0, 0);
        tick(4);

        // Short glitch: PRESS_WAIT visited, then back to IDLE with no pulse.
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(2);
        check_outs("glitch_mid", 0, 1);
        tick(6);
        check_outs("glitch_end", 0, 0);

        // Async reset mid-PRESS_WAIT with the button held.
        btn_raw = 1'b1;
        tick(3);
        check("pw_state", int'(state_dbg), 1);
        #2 reset = 1'b1;
        #1 check_outs("rst_pw", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        expect_ev(1'b0, cyc + Lat);
        tick(Lat + 2);
        check_outs("rst_pw_after", 1, 2);

        // Async reset while PRESSED: level drops at once, no release strobe.
        #2 reset = 1'b1;
        #1 check_outs("rst_pr", 0, 0);
        check("rst_pr_release", int'(btn_release), 0);
        @(negedge clk);
        reset = 1'b0;
        expect_ev(1'b0, cyc + Lat);
        tick(Lat + 2);
        check_outs("rst_pr_after", 1, 2);
        btn_raw = 1'b0;
        expect_ev(1'b1, cyc + Lat);
        tick(Lat + 4);
        check_outs("rst_pr_rel", 0, 0);

        // Long hold: repeats at +10, +13, +16, +19 when auto-repeat is built in.
        btn_raw = 1'b1;
        e0 = cyc + Lat;
        expect_ev(1'b0, e0);
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        expect_ev(1'b0, e0 + 10);
        expect_ev(1'b0, e0 + 13);
        expect_ev(1'b0, e0 + 16);
        expect_ev(1'b0, e0 + 19);
`endif
        tick(Lat + 18);
        check_outs("hold", 1, 2);
        btn_raw = 1'b0;
        expect_ev(1'b1, cyc + Lat);
        tick(Lat + 10);
        check_outs("hold_rel", 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end conditioning stage for a raw push-button input.
- Synchronises the asynchronous pin and debounces it with a saturating stable-sample counter.
- Emits a clean level, a one-cycle press pulse and a one-cycle release pulse.
- btn_pulse / btn_level drive the btn input of the downstream 0-to-10 BCD counter, so each physical press advances that counter by a single, glitch-free event.

Parameters:
- SYNC_STAGES, 2, flops in the input synchroniser chain; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to accept a press or a release; legal range >= 2.
- REPEAT_DELAY, 500, cycles held in PRESSED before the first auto-repeat pulse (used only with the macro); >= 1.
- REPEAT_PERIOD, 100, cycles between subsequent auto-repeat pulses (used only with the macro); >= 1.

Ports:
- clk  in  1  system clock; all flops are rising-edge.
- reset  in  1  asynchronous, active-high reset.
- btn_raw  in  1  raw button pin, asynchronous to clk, 1 = pressed.
- btn_level  out  1  debounced button level, registered.
- btn_pulse  out  1  one-cycle strobe on accepted press (and on auto-repeat), registered.
- btn_release  out  1  one-cycle strobe on accepted release, registered.
- state_dbg  out  2  current FSM state encoding, for debug.

Behaviour:
- Reset asserted: synchroniser flops, counters and FSM clear immediately, regardless of clk.
  - btn_level = 0, btn_pulse = 0, btn_release = 0, state_dbg = IDLE (2'b00).
- Synchroniser: btn_raw passes through SYNC_STAGES flops. Only the last flop output (sync) feeds the FSM.
- FSM encoding: IDLE = 00, PRESS_WAIT = 01, PRESSED = 10, RELEASE_WAIT = 11. One transition per clk edge.
- Stable counter (cnt): width ceil(log2(DEBOUNCE_CYCLES)) + 1.
  - Cleared on every state change except the increments listed below.
  - Never wraps.
- IDLE:
  - sync = 1 -> PRESS_WAIT, cnt = 1.
  - Otherwise stay.
- PRESS_WAIT:
  - sync = 0 -> IDLE, cnt = 0, no pulse (glitch rejected).
  - sync = 1 and cnt < DEBOUNCE_CYCLES-1 -> cnt + 1.
  - sync = 1 and cnt = DEBOUNCE_CYCLES-1 -> PRESSED; btn_level <= 1; btn_pulse <= 1 for exactly one cycle.
- PRESSED:
  - sync = 0 -> RELEASE_WAIT, cnt = 1.
  - Otherwise stay. btn_pulse stays 0 (except auto-repeat).
- RELEASE_WAIT:
  - sync = 1 -> PRESSED, cnt = 0; no new btn_pulse; btn_level stays 1.
  - sync = 0 and cnt = DEBOUNCE_CYCLES-1 -> IDLE; btn_level <= 0; btn_release <= 1 for one cycle.
  - Otherwise cnt + 1.
- Latency, with edge 0 defined as the first edge that samples btn_raw = 1 and raw held stable:
  - btn_pulse is high during the cycle after edge SYNC_STAGES + DEBOUNCE_CYCLES - 1.
  - Release is symmetric and produces btn_release with the same latency.
- btn_pulse and btn_release are never high in the same cycle. Each is high for at most one cycle per event.
- Reset mid-debounce or while PRESSED:
  - Outputs drop to 0 asynchronously; no btn_release is generated.
  - After deassertion, a still-held button must be re-debounced from IDLE and then produces a fresh btn_pulse.
- Reset deassertion is assumed synchronised externally; the block adds no reset synchroniser.

Optional Feature:
- Macro: BTN_CONDITIONER_AUTOREPEAT_EN.
- Defined: a repeat counter runs while in PRESSED.
  - It is cleared to 0 in the cycle PRESSED is entered.
  - After REPEAT_DELAY cycles, btn_pulse fires one cycle, then again every REPEAT_PERIOD cycles while in PRESSED.
  - Leaving PRESSED (including to RELEASE_WAIT) clears the repeat counter. Returning to PRESSED from RELEASE_WAIT restarts the REPEAT_DELAY wait and gives no immediate pulse.
- Not defined: repeat logic is absent; exactly one btn_pulse per accepted press. REPEAT_DELAY and REPEAT_PERIOD are still declared but unused.

Test Plan:
- SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4; raise btn_raw at edge 0 and hold -> btn_pulse = 1 only in the cycle after edge 5; btn_level = 1 from then on; state_dbg = 10.
- Same config; btn_raw high for 2 edges, then low -> no btn_pulse; btn_level remains 0; state_dbg returns to 00.
- Pressed and stable, then drop btn_raw for 2 edges and raise it again -> no btn_release, no second btn_pulse, btn_level stays 1.
- Pressed, then drop btn_raw and hold it low -> btn_release = 1 for one cycle, 5 edges after the first low sample; btn_level = 0.
- Assert reset asynchronously mid-PRESS_WAIT and mid-PRESSED, with btn_raw still high -> outputs 0 immediately; after release, exactly one btn_pulse after full debounce latency.
- With BTN_CONDITIONER_AUTOREPEAT_EN, REPEAT_DELAY = 10, REPEAT_PERIOD = 3; hold 20 cycles past the first pulse -> pulses at +0, +10, +13, +16, +19, and none after release.
